// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter sharing one swap-style hash unit between NUM_REQ requesters.
// Each accepted job returns the previous job's result; results are routed to their owner.
module pipeline_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = $clog2(NUM_REQ),
   parameter int FLUSH_CYCLES = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [16*NUM_REQ-1:0]  req_data,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [15:0]            pipe_data,
   output logic                   pipe_data_valid,
   input  logic                   pipe_data_ready,
   input  logic [15:0]            pipe_result,
   input  logic                   pipe_result_valid,
   output logic                   pipe_result_ready,
   output logic [15:0]            rsp_result,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_valid,
   input  logic                   rsp_ready
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   cur_id_q, cur_id_d;
   logic              cur_dummy_q, cur_dummy_d;
   logic              prev_valid_q, prev_valid_d;
   logic [ID_W-1:0]   prev_id_q, prev_id_d;
   logic              prev_dummy_q, prev_dummy_d;
   logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic [15:0]       pipe_data_q, pipe_data_d;
   logic [15:0]       rsp_result_q, rsp_result_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_valid_q, rsp_valid_d;

   logic              accept;
   logic              any_req;
   logic              grant_ok;
   logic              flush_go;
   logic              granted;
   logic              hi_found;
   logic [ID_W-1:0]   hi_idx, lo_idx, grant_idx;
   logic [15:0]       req_word [NUM_REQ];

   assign accept   = (state_q == ISSUE) && pipe_data_ready;
   assign any_req  = |req_valid;
   assign grant_ok = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
   assign flush_go = (FLUSH_CYCLES != 0) && prev_valid_q && !prev_dummy_q && (idle_cnt_q == CNT_MAX);

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[16*gi +: 16];
      assign req_ready[gi] = accept && !cur_dummy_q && (cur_id_q == ID_W'(gi));
   end

   // Lowest set index at or above ptr wins; otherwise wrap to the lowest set index overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_idx = ID_W'(i);
            if (ID_W'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(i);
            end
         end
      end
   end

   assign grant_idx = hi_found ? hi_idx : lo_idx;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cur_id_d     = cur_id_q;
      cur_dummy_d  = cur_dummy_q;
      prev_valid_d = prev_valid_q;
      prev_id_d    = prev_id_q;
      prev_dummy_d = prev_dummy_q;
      pipe_data_d  = pipe_data_q;
      rsp_result_d = rsp_result_q;
      rsp_id_d     = rsp_id_q;
      rsp_valid_d  = rsp_valid_q;
      granted      = 1'b0;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (grant_ok && any_req) begin
               granted     = 1'b1;
               state_d     = ISSUE;
               pipe_data_d = req_word[grant_idx];
               cur_id_d    = grant_idx;
               cur_dummy_d = 1'b0;
            end else if (grant_ok && flush_go) begin
               granted     = 1'b1;
               state_d     = ISSUE;
               pipe_data_d = '0;
               cur_dummy_d = 1'b1;
            end
         end
         ISSUE: begin
            if (pipe_data_ready) begin
               // The slot is known empty here: grants are withheld while it is occupied.
               if (prev_valid_q && !prev_dummy_q && pipe_result_valid) begin
                  rsp_valid_d  = 1'b1;
                  rsp_result_d = pipe_result;
                  rsp_id_d     = prev_id_q;
               end
               prev_valid_d = 1'b1;
               prev_id_d    = cur_id_q;
               prev_dummy_d = cur_dummy_q;
               if (!cur_dummy_q) begin
                  ptr_d = (cur_id_q == LAST_ID) ? '0 : cur_id_q + 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (granted || any_req) begin
         idle_cnt_d = '0;
      end else if ((state_q == IDLE) && (idle_cnt_q != CNT_MAX)) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end else begin
         idle_cnt_d = idle_cnt_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         cur_id_q     <= '0;
         cur_dummy_q  <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_id_q    <= '0;
         prev_dummy_q <= 1'b0;
         idle_cnt_q   <= '0;
         pipe_data_q  <= '0;
         rsp_result_q <= '0;
         rsp_id_q     <= '0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cur_id_q     <= cur_id_d;
         cur_dummy_q  <= cur_dummy_d;
         prev_valid_q <= prev_valid_d;
         prev_id_q    <= prev_id_d;
         prev_dummy_q <= prev_dummy_d;
         idle_cnt_q   <= idle_cnt_d;
         pipe_data_q  <= pipe_data_d;
         rsp_result_q <= rsp_result_d;
         rsp_id_q     <= rsp_id_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign pipe_data         = pipe_data_q;
   assign pipe_data_valid   = (state_q == ISSUE) && !pipe_data_ready;
   assign pipe_result_ready = (state_q == ISSUE) && !pipe_data_ready;
   assign rsp_result        = rsp_result_q;
   assign rsp_id            = rsp_id_q;
   assign rsp_valid         = rsp_valid_q;

endmodule
